pdm_dac_multi: RTL and testbench

//   Multi-channel PDM audio DAC: accepts signed PCM frames via valid/ready, holds them at the PCM rate,

---
 rtl/pdm_dac_multi_pkg.sv | 28 ++
 rtl/pdm_sd_channel.sv | 74 +++++++
 rtl/pdm_dac_multi.sv | 109 ++++++++++
 tb/tb_pdm_dac_multi.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pdm_dac_multi_pkg.sv
// Shared constants, hold-register state type and parameter helpers for the PDM DAC.
// Other audio blocks reuse the CLK_DIV/OSR legality helpers.
package pdm_dac_multi_pkg;

    localparam int DEF_WIDTH    = 16;
    localparam int DEF_CHANNELS = 2;
    localparam int DEF_CLK_DIV  = 5;
    localparam int DEF_OSR      = 64;

    typedef enum logic {
        HOLD_EMPTY = 1'b0,
        HOLD_FULL  = 1'b1
    } hold_state_t;

    function automatic bit clk_div_legal(input int clk_div);
        return clk_div >= 1;
    endfunction

    function automatic bit osr_legal(input int osr);
        return osr >= 2;
    endfunction

    // Counter width for a modulo-n counter; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pdm_sd_channel.sv
// One delta-sigma channel: signed PCM in, registered 1-bit PDM out, stepping on ce.
// Define PDM_SECOND_ORDER_EN for the saturating 2nd-order CIFB loop; otherwise 1st-order.
module pdm_sd_channel #(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ce,
    input  logic signed [WIDTH-1:0] x,
    output logic                    pdm
);

`ifdef PDM_SECOND_ORDER_EN
    localparam int IW = WIDTH + 3;
    localparam int SW = WIDTH + 5;

    localparam logic signed [SW-1:0] I_MAX = {{(SW-WIDTH-2){1'b0}}, {(WIDTH+2){1'b1}}};
    localparam logic signed [SW-1:0] I_MIN = -I_MAX;
    localparam logic signed [SW-1:0] FB    = {{(SW-WIDTH){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

    logic signed [IW-1:0] i1, i2, i1_next, i2_next;
    logic signed [SW-1:0] x_w, i1_w, i2_w, fb, s1, s2;

    function automatic logic signed [IW-1:0] sat(input logic signed [SW-1:0] v);
        if (v > I_MAX)
            return I_MAX[IW-1:0];
        else if (v < I_MIN)
            return I_MIN[IW-1:0];
        else
            return v[IW-1:0];
    endfunction

    // Sums are formed two bits wider than the integrators so clamping sees the true value.
    always_comb begin
        x_w     = {{(SW-WIDTH){x[WIDTH-1]}}, x};
        i1_w    = {{(SW-IW){i1[IW-1]}}, i1};
        i2_w    = {{(SW-IW){i2[IW-1]}}, i2};
        fb      = pdm ? FB : -FB;
        s1      = i1_w + x_w - fb;
        s2      = i2_w + i1_w - fb;
        i1_next = sat(s1);
        i2_next = sat(s2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i1  <= '0;
            i2  <= '0;
            pdm <= 1'b0;
        end else if (ce) begin
            i1  <= i1_next;
            i2  <= i2_next;
            pdm <= ~i2_next[IW-1];
        end
    end
`else
    logic [WIDTH-1:0] acc;
    logic [WIDTH:0]   sum;

    // Offset-binary input: flipping the sign bit maps -full..+full onto 0..2^WIDTH-1.
    always_comb sum = {1'b0, acc} + {1'b0, ~x[WIDTH-1], x[WIDTH-2:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            pdm <= 1'b0;
        end else if (ce) begin
            acc <= sum[WIDTH-1:0];
            pdm <= sum[WIDTH];
        end
    end
`endif

endmodule

// File: rtl/pdm_dac_multi.sv
// Multi-channel PDM audio DAC: PCM frames via valid/ready, held per PCM period, one PDM bit per channel.
// Define PDM_SECOND_ORDER_EN to build every channel with the 2nd-order modulator.
module pdm_dac_multi
    import pdm_dac_multi_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int OSR      = DEF_OSR
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    output logic [CHANNELS-1:0]       pdm_out,
    output logic                      sample_req,
    output logic                      underrun
);

    localparam int DIV_W = cnt_width(CLK_DIV);
    localparam int OSR_W = cnt_width(OSR);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [OSR_W-1:0] OSR_LAST = OSR_W'(OSR - 1);

    generate
        if (!clk_div_legal(CLK_DIV) || !osr_legal(OSR)) begin : g_bad_param
            $error("pdm_dac_multi: CLK_DIV must be >= 1 and OSR must be >= 2");
        end
    endgenerate

    logic [DIV_W-1:0]          div_cnt;
    logic                      ce;
    logic [OSR_W-1:0]          osr_cnt;
    logic                      load;
    logic                      xfer;
    hold_state_t               hold_state, hold_next;
    logic [CHANNELS*WIDTH-1:0] hold_data;
    logic [CHANNELS*WIDTH-1:0] active;

    assign load = ce && (osr_cnt == OSR_LAST);
    assign xfer = s_valid && s_ready;

    always_ff @(posedge clk) begin
        // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            div_cnt <= '0;
            ce      <= 1'b0;
            osr_cnt <= '0;
        end else begin
            ce      <= (div_cnt == DIV_LAST);
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
            if (ce)
                osr_cnt <= (osr_cnt == OSR_LAST) ? '0 : osr_cnt + 1'b1;
        end
    end

    always_comb begin
        // NOTE: default assigned first so no path leaves hold_next unassigned (no latch).
        hold_next = hold_state;
        case (hold_state)
            HOLD_EMPTY: if (xfer) hold_next = HOLD_FULL;
            HOLD_FULL:  if (load) hold_next = HOLD_EMPTY;
            default:    hold_next = HOLD_EMPTY;
        endcase
    end

    // A load decides full/empty on the pre-edge hold state, so a same-cycle write is an underrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_state <= HOLD_EMPTY;
            s_ready    <= 1'b0;
            active     <= '0;
            sample_req <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            hold_state <= hold_next;
            s_ready    <= (hold_next == HOLD_EMPTY);
            sample_req <= load;
            if (load) begin
                if (hold_state == HOLD_FULL)
                    active <= hold_data;
                else
                    underrun <= 1'b1;
            end
        end
    end

    // NOTE: hold_data is not reset; hold_state alone says whether its contents are meaningful.
    always_ff @(posedge clk) begin
        if (xfer)
            hold_data <= s_data;
    end

    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
            pdm_sd_channel #(
                .WIDTH(WIDTH)
            ) u_ch (
                .clk(clk),
                .rst(rst),
                .ce (ce),
                .x  (active[c*WIDTH +: WIDTH]),
                .pdm(pdm_out[c])
            );
        end
    endgenerate

endmodule

// File: tb/tb_pdm_dac_multi.sv
// Directed bench for pdm_dac_multi: reset, midscale toggling, density table, handshake and underrun.
// Cycle numbers count clk edges since reset release; ticks fall on cycles 5,10,... and show a cycle later.
module tb_pdm_dac_multi;

    localparam int WIDTH    = 16;
    localparam int CHANNELS = 2;
    localparam int CLK_DIV  = 5;
    localparam int OSR      = 64;
`ifdef PDM_SECOND_ORDER_EN
    localparam int TOL = 2;
`else
    localparam int TOL = 1;
`endif

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [CHANNELS*WIDTH-1:0] s_data = '0;
    logic                      s_valid = 1'b0;
    logic                      s_ready;
    logic [CHANNELS-1:0]       pdm_out;
    logic                      sample_req;
    logic                      underrun;

    pdm_dac_multi #(
        .WIDTH   (WIDTH),
        .CHANNELS(CHANNELS),
        .CLK_DIV (CLK_DIV),
        .OSR     (OSR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .pdm_out   (pdm_out),
        .sample_req(sample_req),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ch0;
        logic [15:0] ch1;
        int          ticks;
        int          exp0;
        int          exp1;
    } dens_vec_t;

    dens_vec_t vecs[3];
    int        errors = 0;
    int        checks = 0;
    int        cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_near(input string name, input int act, input int exp, input int tol);
        checks++;
        if (act < exp - tol || act > exp + tol) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d +/-%0d", name, act, exp, tol);
        end
    endtask

    task automatic goto(input int target);
        while (cyc < target) begin
            @(posedge clk);
            cyc++;
        end
        #1;
    endtask

    // Leaves the bench 1 time unit into cycle 0, the first cycle with rst low.
    task automatic do_reset(input int n);
        rst     = 1'b1;
        s_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    // Offer a frame at cycle 0; s_ready rises in cycle 1, so it transfers at the end of cycle 1.
    task automatic push_first(input logic [15:0] ch0, input logic [15:0] ch1);
        s_data  = {ch1, ch0};
        s_valid = 1'b1;
        goto(2);
        s_valid = 1'b0;
    endtask

    // Must start on a cycle where pdm_out has just updated (cycle 6 + 5k).
    task automatic count_ones(input int ticks, output int n0, output int n1);
        n0 = 0;
        n1 = 0;
        for (int t = 0; t < ticks; t++) begin
            n0 += int'(pdm_out[0]);
            n1 += int'(pdm_out[1]);
            goto(cyc + CLK_DIV);
        end
    endtask

    initial begin
        int n0, n1;
        int xfer_cyc[$];

        vecs[0] = '{ch0: 16'h4000, ch1: 16'hC000, ticks: 4096, exp0: 3072, exp1: 1024};
        vecs[1] = '{ch0: 16'h0000, ch1: 16'h8000, ticks: 1024, exp0: 512,  exp1: 0};
        vecs[2] = '{ch0: 16'h7FFF, ch1: 16'h2000, ticks: 1024, exp0: 1024, exp1: 640};

        // Reset state
        do_reset(3);
        check("reset_pdm_out", 32'(pdm_out), 32'h0);
        check("reset_underrun", 32'(underrun), 32'h0);
        check("reset_sample_req", 32'(sample_req), 32'h0);
        goto(1);
        check("reset_s_ready", 32'(s_ready), 32'h1);

        // Midscale frame: first-order output alternates from the first tick
        do_reset(3);
        push_first(16'h0000, 16'h0000);
`ifndef PDM_SECOND_ORDER_EN
        for (int k = 0; k < 4; k++) begin
            goto(6 + CLK_DIV * k);
            check($sformatf("midscale_tick%0d", k), 32'(pdm_out), (k % 2 == 1) ? 32'h3 : 32'h0);
        end
`endif

        // Density table: one frame, later loads underrun and keep the frame active
        for (int v = 0; v < 3; v++) begin
            do_reset(3);
            push_first(vecs[v].ch0, vecs[v].ch1);
            goto(OSR * CLK_DIV + 6);
            count_ones(vecs[v].ticks, n0, n1);
            check_near($sformatf("density%0d_ch0", v), n0, vecs[v].exp0, TOL);
            check_near($sformatf("density%0d_ch1", v), n1, vecs[v].exp1, TOL);
        end

        // Backpressure: s_valid held high, one transfer per PCM period
        do_reset(3);
        s_valid = 1'b1;
        s_data  = 32'h0001_0001;
        for (int c = 0; c < 1000; c++) begin
            goto(c);
            if (s_ready && s_valid) begin
                xfer_cyc.push_back(c);
                goto(c + 1);
                s_data = s_data + 32'h0001_0001;
            end
        end
        s_valid = 1'b0;
        check("bp_xfer_count", 32'(xfer_cyc.size()), 32'd4);
        if (xfer_cyc.size() == 4) begin
            check("bp_first_xfer", 32'(xfer_cyc[0]), 32'd1);
            for (int i = 1; i < 4; i++)
                check($sformatf("bp_gap%0d", i), 32'(xfer_cyc[i] - xfer_cyc[i-1]), 32'(OSR * CLK_DIV));
        end
        check("bp_no_underrun", 32'(underrun), 32'h0);

        // Underrun after a single frame
        do_reset(3);
        push_first(16'h1234, 16'h5678);
        goto(320);
        check("ur_pre_load_req", 32'(sample_req), 32'h0);
        goto(321);
        check("ur_load1_req", 32'(sample_req), 32'h1);
        check("ur_load1_underrun", 32'(underrun), 32'h0);
        check("ur_load1_ready", 32'(s_ready), 32'h1);
        goto(322);
        check("ur_req_one_cycle", 32'(sample_req), 32'h0);
        goto(640);
        check("ur_before_load2", 32'(underrun), 32'h0);
        goto(641);
        check("ur_load2_underrun", 32'(underrun), 32'h1);
        check("ur_load2_req", 32'(sample_req), 32'h1);

        // Handshake in the load cycle with hold empty: underrun, frame kept for next load
        do_reset(3);
        goto(320);
        check("same_ready", 32'(s_ready), 32'h1);
        s_data  = {16'hC000, 16'h4000};
        s_valid = 1'b1;
        goto(321);
        s_valid = 1'b0;
        check("same_underrun", 32'(underrun), 32'h1);
        check("same_stored", 32'(s_ready), 32'h0);
        check("same_req", 32'(sample_req), 32'h1);
        goto(641);
        check("same_loaded", 32'(s_ready), 32'h1);
        goto(646);
        count_ones(256, n0, n1);
        check_near("same_density_ch0", n0, 192, TOL);
        check_near("same_density_ch1", n1, 64, TOL);

        // Reset mid-frame with a pending frame and live modulator state
        do_reset(3);
        push_first(16'h6000, 16'h1000);
        goto(330);
        s_data  = {16'h7000, 16'h7000};
        s_valid = 1'b1;
        goto(331);
        s_valid = 1'b0;
        goto(340);
        check("mid_hold_full", 32'(s_ready), 32'h0);
        do_reset(1);
        check("mid_pdm_cleared", 32'(pdm_out), 32'h0);
        goto(1);
        check("mid_ready", 32'(s_ready), 32'h1);
        check("mid_underrun_clear", 32'(underrun), 32'h0);
        goto(321);
        check("mid_pending_dropped", 32'(underrun), 32'h1);
        goto(326);
        count_ones(256, n0, n1);
        check_near("mid_density_ch0", n0, 128, TOL);
        check_near("mid_density_ch1", n1, 128, TOL);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
